down_counter_reload: RTL

//   Loadable synchronous down counter and timer. It is the counting-down

---
 rtl/down_counter_reload.sv | 99 +++++++++
 1 files changed

// File: rtl/down_counter_reload.sv
// Loadable down counter / timer: counts a loaded start value N down to 0 and pulses tc
// as q reaches 0, then either stops in DONE (one-shot) or reloads N (auto-reload).
//
// state | meaning
// IDLE  | q holds, en ignored
// RUN   | counting on enabled cycles
// DONE  | one-shot finished, q=0 held, done=1
module down_counter_reload #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= IDLE;
      count_q  <= ZERO;
      reload_q <= ZERO;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    done_d   = done_q;

    if (load) begin
      // A zero start value parks the block instead of producing an instant tc.
      count_d  = load_val;
      reload_d = load_val;
      done_d   = 1'b0;
      state_d  = (load_val != ZERO) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (en) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else if (count_q == ONE) begin
              count_d = ZERO;
              tc_d    = 1'b1;
              if (!auto_reload) begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end else begin
              count_d = reload_q;
            end
          end
        end
        DONE: begin
          count_d = ZERO;
        end
        default: begin
        end
      endcase
    end
  end

  assign q    = count_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule
